// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder for the CPU load/store port.
// One request is accepted per handshake, held for LATENCY wait cycles, then the
// access is performed on the RESP-entry edge and rvalid pulses for one cycle.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // Fields of the access performed on this edge (live inputs when LATENCY=0)
    logic              acc_go_s;
    logic              acc_we_s;
    logic [3:0]        acc_be_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [31:0]       acc_wdata_s;

    // Replace only the byte lanes selected by the enables
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign ready = (state_r == IDLE);

    // Decide whether the access fires on the coming edge and which fields it uses
    always_comb begin
        acc_go_s    = 1'b0;
        acc_we_s    = we_r;
        acc_be_s    = be_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (req && (LAT == 4'd0) && rst) begin
                    acc_go_s    = 1'b1;
                    acc_we_s    = we;
                    acc_be_s    = be;
                    acc_addr_s  = addr;
                    acc_wdata_s = wdata;
                end else begin
                    acc_go_s    = 1'b0;
                end
            end
            WAIT: begin
                if ((cnt_r == 4'd0) && rst) begin
                    acc_go_s = 1'b1;
                end else begin
                    acc_go_s = 1'b0;
                end
            end
            default: begin
                acc_go_s = 1'b0;
            end
        endcase
    end

    // Array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (acc_go_s && acc_we_s) begin
            mem[acc_addr_s] <= merge_bytes(mem[acc_addr_s], acc_wdata_s, acc_be_s);
        end
    end

    // Request FSM: capture, wait countdown, one-cycle response, read data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'h0;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    rvalid <= 1'b0;
                    if (req) begin
                        we_r    <= we;
                        be_r    <= be;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        if (LAT == 4'd0) begin
                            state_r <= RESP;
                            rvalid  <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT - 4'd1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= RESP;
                        rvalid  <= 1'b1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    rvalid  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rvalid  <= 1'b0;
                end
            endcase
            // rdata only moves on a read completion
            if (acc_go_s && !acc_we_s) begin
                rdata <= mem[acc_addr_s];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: instance 0 runs LATENCY=2, instance 1
// runs LATENCY=0. The stimulus side updates a word-array model and queues the
// expected completion cycle and rdata; a negedge monitor pops and compares.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  be    [2];
    logic [9:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  ready;
    logic [1:0]  rvalid;
    logic [31:0] rdata [2];

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_m   [2][1024];
    logic [31:0] last_rd [2];
    int          last_acc[2];
    int          cyc;
    int          checks;
    int          errors;

    dm_responder #(.ADDR_W(10), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .be(be[0]),
        .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
        .rvalid(rvalid[0]), .rdata(rdata[0]));

    dm_responder #(.ADDR_W(10), .LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .be(be[1]),
        .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
        .rvalid(rvalid[1]), .rdata(rdata[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter: value k after the k-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic drive(input int d, input logic r, input logic w, input logic [3:0] b,
                         input logic [9:0] a, input logic [31:0] wd);
        req[d] = r; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    endtask

    // Must be called at a falling edge; returns at the falling edge where ready is back
    task automatic issue(input int d, input logic w, input logic [3:0] b, input logic [9:0] a,
                         input logic [31:0] wd, input bit scramble, input bit keep);
        exp_t e;
        bit   ok;
        int   lat;
        lat = (d == 0) ? 2 : 0;
        ok  = 1'b0;
        drive(d, 1'b1, w, b, a, wd);
        for (int t = 0; t < 50 && !ok; t++) begin
            if (ready[d] === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            chk($sformatf("accept_timeout_dut%0d", d), 32'd0, 32'd1);
            req[d] = 1'b0;
            return;
        end
        last_acc[d] = cyc + 1;
        e.cyc = cyc + 1 + lat;
        if (w) begin
            mem_m[d][a] = lane_merge(mem_m[d][a], wd, b);
            e.data = last_rd[d];
        end else begin
            e.data = mem_m[d][a];
            last_rd[d] = e.data;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        for (int j = 0; j <= lat; j++) begin
            @(negedge clk);
            if (j == 0) begin
                if (scramble) drive(d, 1'b0, ~w, 4'($urandom), 10'($urandom), $urandom);
                else if (!keep) req[d] = 1'b0;
            end
            chk($sformatf("ready_busy_dut%0d", d), 32'(ready[d]), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("ready_back_dut%0d", d), 32'(ready[d]), 32'd1);
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (rvalid[d] !== 1'b0) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid_dut%0d actual=%b required=0 cycle=%0d", d, rvalid[d], cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rvalid_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("rdata_dut%0d", d), rdata[d], e.data);
            end
        end
    endtask

    // monitor: compare every completion pulse against the scoreboard head
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        cyc = 0; checks = 0; errors = 0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        last_acc[0] = 0; last_acc[1] = 0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);

        // reset with req pulses that must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) drive(d, 1'(i[0]), 1'b1, 4'hF, 10'(i), $urandom);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready_dut%0d", d), 32'(ready[d]), 32'd1);
            chk($sformatf("reset_rvalid_dut%0d", d), 32'(rvalid[d]), 32'd0);
            chk($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
        end
        @(negedge clk);

        // LATENCY=2 write/read
        issue(0, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(0, 1'b0, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);
        // byte enables, including an all-zero enable write
        issue(0, 1'b1, 4'hF, 10'h007, 32'h11223344, 1'b0, 1'b0);
        issue(0, 1'b1, 4'b0101, 10'h007, 32'hAABBCCDD, 1'b0, 1'b0);
        issue(0, 1'b0, 4'h0, 10'h007, 32'h0, 1'b0, 1'b0);
        issue(0, 1'b1, 4'h0, 10'h007, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(0, 1'b0, 4'h0, 10'h007, 32'h0, 1'b0, 1'b0);
        // inputs scrambled right after acceptance
        issue(0, 1'b1, 4'hF, 10'h003, 32'h12345678, 1'b1, 1'b0);
        issue(0, 1'b0, 4'h0, 10'h003, 32'h0, 1'b1, 1'b0);
        issue(0, 1'b0, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);

        // reset during WAIT aborts the write
        issue(0, 1'b1, 4'hF, 10'h009, 32'h0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b1, 4'hF, 10'h009, 32'hCAFEF00D);
        @(negedge clk);
        req[0] = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        chk("midwait_ready", 32'(ready[0]), 32'd1);
        chk("midwait_rvalid", 32'(rvalid[0]), 32'd0);
        @(negedge clk);
        issue(0, 1'b0, 4'h0, 10'h009, 32'h0, 1'b0, 1'b0);

        // LATENCY=0: single read, then req held continuously
        issue(1, 1'b1, 4'hF, 10'h005, 32'h0BADF00D, 1'b0, 1'b0);
        issue(1, 1'b0, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = last_acc[1];
            issue(1, 1'(i[0]), 4'hF, 10'h005, 32'(i * 7 + 1), 1'b0, 1'b1);
            if (i > 0) chk("b2b_spacing", 32'(last_acc[1] - prev), 32'd2);
        end
        req[1] = 1'b0;
        @(negedge clk);

        // randomized traffic on a small address window
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16; a++) issue(d, 1'b1, 4'hF, 10'(a), $urandom, 1'b0, 1'b0);
            for (int n = 0; n < 40; n++)
                issue(d, 1'($urandom_range(0, 1)), 4'($urandom), 10'($urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("pending_dut0", 32'(q0.size()), 32'd0);
        chk("pending_dut1", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder. It is the memory-side end of the CPU load/store request interface.
- Accepts one word-addressed read or write request per handshake, holds the access for a programmable number of wait cycles, then completes it and raises a one-cycle response pulse.
- Replaces the zero-latency data memory when the datapath runs with a stalling memory port. It sits between the CPU's load/store unit and a 1024-word RAM array.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2, wait cycles inserted between request acceptance and completion; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req  in  1  request valid from CPU.
- we  in  1  1 = write, 0 = read; sampled with req.
- be  in  4  byte enables for writes, be[i] selects wdata[8i+7:8i]; ignored on reads.
- addr  in  ADDR_W  word address.
- wdata  in  32  write data.
- ready  out  1  responder idle and able to accept; combinational from state.
- rvalid  out  1  one-cycle completion pulse, for both reads and writes.
- rdata  out  32  read data; valid while rvalid=1 on a read.

Behaviour:
- States: IDLE, WAIT, RESP. 4-bit wait counter cnt. Capture registers hold we, be, addr and wdata.
- While rst=0 (asynchronous):
  - state=IDLE, cnt=0, rvalid=0, rdata=32'h0, capture registers cleared.
  - ready=1, because state is IDLE, but req is ignored while reset is asserted.
  - Array contents are not reset.
- IDLE: ready=1.
  - Accept at rising edge E0 when req=1 && ready=1; capture request fields.
  - LATENCY>0: go to WAIT with cnt=LATENCY-1.
  - LATENCY=0: go directly to RESP and perform the access at E0.
- WAIT: ready=0.
  - cnt≠0: decrement cnt.
  - cnt=0: go to RESP at edge E0+LATENCY and perform the access on that same edge.
- Access:
  - Write: each byte lane with be[i]=1 is updated from the captured wdata. Lanes with be[i]=0 keep their old value. rdata is unchanged.
  - Read: rdata is loaded with the array word at the captured addr.
- RESP: rvalid=1 for exactly the one cycle between E0+LATENCY and E0+LATENCY+1; ready=0. The next edge returns to IDLE.
- Latency: rvalid is high in cycle LATENCY+1 counted from the acceptance edge. Maximum throughput is one request per LATENCY+2 cycles.
- req while ready=0 is ignored, not queued. The CPU must hold req until it sees ready=1 at a rising edge.
- Input changes after acceptance have no effect; only captured values are used.
- Write with be=4'b0000: no array change, but the transaction still completes with the normal rvalid pulse.
- rdata holds its last read value through writes, IDLE and WAIT. It changes only on read completion or reset.
- Address wrap: addr covers the array exactly, so there is no out-of-range case.
- Reset mid-transaction:
  - In WAIT: abort, no array write occurs, no rvalid.
  - In RESP: the write has already committed at the RESP-entry edge; rvalid drops asynchronously.
- Read-after-write to the same address in consecutive transactions returns the newly written data; no bypass is needed because transactions are serialized.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release → ready=1, rvalid=0, rdata=0; req pulses during reset produce no rvalid.
- Write/read, LATENCY=2:
  - Write addr=10'h005, wdata=32'hDEADBEEF, be=4'hF accepted at E0 → ready=0 for 3 cycles, rvalid=1 only in cycle 3, ready=1 in cycle 4.
  - Read of addr 5 → rdata=32'hDEADBEEF with rvalid three cycles after acceptance.
- Byte enables: preload addr 7 = 32'h11223344; write wdata=32'hAABBCCDD, be=4'b0101 → readback 32'h11BB33DD. A write with be=0 leaves the word unchanged and still pulses rvalid.
- LATENCY=0 and back-to-back: accepted read pulses rvalid in the next cycle. req held high continuously is accepted every 2 cycles; a req asserted in RESP is not accepted until IDLE.
- Input hold: change addr/wdata/we on the cycle after acceptance → the operation uses the captured values; rdata is unchanged across the intervening write transaction.
- Reset mid-WAIT: write addr 9 = 32'hCAFEF00D after a prior value 32'h0; assert rst during WAIT → no rvalid; after release, a read of addr 9 returns 32'h0.
